// File: rtl/ras_ctrl.sv
// Return-address-stack controller: owns pointer, occupancy and a two-entry top cache
// in front of a 1-cycle-latency dual-port BRAM (port A writes, port B reads).
module ras_ctrl #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 36,
  localparam int ADDR = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_addr_i,
  input  logic             recover_i,
  input  logic [ADDR-1:0]  recover_ptr_i,
  input  logic [ADDR:0]    recover_cnt_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] top_o,
  output logic             top_valid_o,
  output logic [ADDR:0]    count_o,
  output logic [ADDR-1:0]  ptr_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             mem_wea,
  output logic [ADDR-1:0]  mem_waddra,
  output logic [WIDTH-1:0] mem_wia,
  output logic             mem_reb,
  output logic [ADDR-1:0]  mem_raddrb,
  input  logic [WIDTH-1:0] mem_dob
);

  typedef enum logic [1:0] {READY, REFILL_TOP, REFILL_NEXT} state_t;

  localparam logic [ADDR:0]   CNT_FULL = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0]   CNT_ONE  = (ADDR+1)'(1);
  localparam logic [ADDR-1:0] PTR_ONE  = ADDR'(1);
  localparam logic [ADDR-1:0] PTR_TWO  = ADDR'(2);
  localparam logic [ADDR-1:0] PTR_THREE = ADDR'(3);

  state_t           state_reg;
  logic [ADDR-1:0]  ptr_reg;
  logic [ADDR:0]    count_reg;
  logic [WIDTH-1:0] top_reg;
  logic [WIDTH-1:0] next_reg;
  logic             pend_reg;
  logic             overflow_reg;
  logic             underflow_reg;

  logic             ready;
  logic             empty;
  logic             full;
  logic             do_recover;
  logic             do_push;
  logic             do_replace;
  logic             do_pop;
  logic             do_underflow;
  logic [WIDTH-1:0] next_eff;
  logic [ADDR-1:0]  ptr_m1;
  logic [ADDR-1:0]  ptr_m2;
  logic [ADDR-1:0]  ptr_m3;

  assign ready  = (state_reg == READY);
  assign empty  = (count_reg == '0);
  assign full   = (count_reg == CNT_FULL);
  assign ptr_m1 = ptr_reg - PTR_ONE;
  assign ptr_m2 = ptr_reg - PTR_TWO;
  assign ptr_m3 = ptr_reg - PTR_THREE;

  // A pop last cycle left the new second entry in flight on port B.
  assign next_eff = pend_reg ? mem_dob : next_reg;

  // Recovery wins; push+pop on an empty stack degenerates to a plain push.
  assign do_recover   = ready & recover_i;
  assign do_replace   = ready & ~recover_i & push_i & pop_i & ~empty;
  assign do_push      = ready & ~recover_i & push_i & ~do_replace;
  assign do_pop       = ready & ~recover_i & pop_i & ~push_i & ~empty;
  assign do_underflow = ready & ~recover_i & pop_i & ~push_i & empty;

  always_comb begin
    mem_wea    = 1'b0;
    mem_waddra = '0;
    mem_wia    = '0;
    mem_reb    = 1'b0;
    mem_raddrb = '0;
    if (do_push) begin
      mem_wea    = 1'b1;
      mem_waddra = ptr_reg;
      mem_wia    = push_addr_i;
    end else if (do_replace) begin
      mem_wea    = 1'b1;
      mem_waddra = ptr_m1;
      mem_wia    = push_addr_i;
    end
    // After a pop the new second entry sits at old ptr-3.
    if (do_recover) begin
      mem_reb    = 1'b1;
      mem_raddrb = recover_ptr_i - PTR_ONE;
    end else if (do_pop) begin
      mem_reb    = 1'b1;
      mem_raddrb = ptr_m3;
    end else if (state_reg == REFILL_TOP) begin
      mem_reb    = 1'b1;
      mem_raddrb = ptr_m2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= READY;
      ptr_reg       <= '0;
      count_reg     <= '0;
      top_reg       <= '0;
      next_reg      <= '0;
      pend_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= do_push & full;
      underflow_reg <= do_underflow;
      case (state_reg)
        READY: begin
          if (do_recover) begin
            ptr_reg   <= recover_ptr_i;
            count_reg <= recover_cnt_i;
            pend_reg  <= 1'b0;
            state_reg <= REFILL_TOP;
          end else if (do_push) begin
            top_reg  <= push_addr_i;
            next_reg <= top_reg;
            pend_reg <= 1'b0;
            ptr_reg  <= ptr_reg + PTR_ONE;
            if (!full) begin
              count_reg <= count_reg + CNT_ONE;
            end
          end else if (do_replace) begin
            top_reg <= push_addr_i;
            if (pend_reg) begin
              next_reg <= mem_dob;
            end
            pend_reg <= 1'b0;
          end else if (do_pop) begin
            top_reg   <= next_eff;
            pend_reg  <= 1'b1;
            ptr_reg   <= ptr_m1;
            count_reg <= count_reg - CNT_ONE;
          end else if (pend_reg) begin
            next_reg <= mem_dob;
            pend_reg <= 1'b0;
          end
        end
        REFILL_TOP: begin
          top_reg   <= mem_dob;
          state_reg <= REFILL_NEXT;
        end
        REFILL_NEXT: begin
          next_reg  <= mem_dob;
          state_reg <= READY;
        end
        default: state_reg <= READY;
      endcase
    end
  end

  assign ready_o     = ready;
  assign top_o       = top_reg;
  assign top_valid_o = ~empty;
  assign count_o     = count_reg;
  assign ptr_o       = ptr_reg;
  assign overflow_o  = overflow_reg;
  assign underflow_o = underflow_reg;

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: BRAM model plus an abstract stack model (memory array, pointer,
// occupancy, recovery busy counter) driven by directed and random stimulus.
module tb_ras_ctrl;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int ADDR  = $clog2(DEPTH);
  localparam int M     = DEPTH - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             push_i = 1'b0;
  logic             pop_i = 1'b0;
  logic [WIDTH-1:0] push_addr_i = '0;
  logic             recover_i = 1'b0;
  logic [ADDR-1:0]  recover_ptr_i = '0;
  logic [ADDR:0]    recover_cnt_i = '0;
  logic             ready_o;
  logic [WIDTH-1:0] top_o;
  logic             top_valid_o;
  logic [ADDR:0]    count_o;
  logic [ADDR-1:0]  ptr_o;
  logic             overflow_o;
  logic             underflow_o;
  logic             mem_wea;
  logic [ADDR-1:0]  mem_waddra;
  logic [WIDTH-1:0] mem_wia;
  logic             mem_reb;
  logic [ADDR-1:0]  mem_raddrb;
  logic [WIDTH-1:0] mem_dob = '0;

  ras_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_i(push_i), .pop_i(pop_i), .push_addr_i(push_addr_i),
    .recover_i(recover_i), .recover_ptr_i(recover_ptr_i), .recover_cnt_i(recover_cnt_i),
    .ready_o(ready_o), .top_o(top_o), .top_valid_o(top_valid_o),
    .count_o(count_o), .ptr_o(ptr_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o),
    .mem_wea(mem_wea), .mem_waddra(mem_waddra), .mem_wia(mem_wia),
    .mem_reb(mem_reb), .mem_raddrb(mem_raddrb), .mem_dob(mem_dob)
  );

  always #5 clk = ~clk;

  // Simple dual-port BRAM with registered read.
  logic [WIDTH-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (mem_wea) bram[mem_waddra] <= mem_wia;
    if (mem_reb) mem_dob <= bram[mem_raddrb];
  end

  // Abstract model: logical stack storage, pointer, count, cycles left in recovery.
  logic [WIDTH-1:0] mdl_mem [DEPTH];
  int mdl_ptr  = 0;
  int mdl_cnt  = 0;
  int mdl_busy = 0;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic cycle(input bit p, input bit q, input logic [WIDTH-1:0] d,
                       input bit r, input int rp, input int rc);
    bit rdy, exp_we, exp_re, exp_ovf, exp_udf;
    int exp_wa, exp_ra;
    @(negedge clk);
    push_i = p; pop_i = q; push_addr_i = d; recover_i = r;
    recover_ptr_i = ADDR'(rp); recover_cnt_i = (ADDR+1)'(rc);
    #1;
    rdy = (mdl_busy == 0);
    exp_we = 0; exp_re = 0; exp_ovf = 0; exp_udf = 0; exp_wa = 0; exp_ra = 0;
    if (mdl_busy == 2) begin
      exp_re = 1; exp_ra = (mdl_ptr - 2) & M;
    end
    if (mdl_busy > 0) begin
      mdl_busy--;
    end else if (r) begin
      exp_re = 1; exp_ra = (rp - 1) & M;
      mdl_ptr = rp; mdl_cnt = rc; mdl_busy = 2;
    end else if (p && q && mdl_cnt > 0) begin
      exp_we = 1; exp_wa = (mdl_ptr - 1) & M;
      mdl_mem[exp_wa] = d;
    end else if (p) begin
      exp_we = 1; exp_wa = mdl_ptr;
      mdl_mem[exp_wa] = d;
      exp_ovf = (mdl_cnt == DEPTH);
      mdl_ptr = (mdl_ptr + 1) & M;
      if (mdl_cnt < DEPTH) mdl_cnt++;
    end else if (q) begin
      if (mdl_cnt == 0) exp_udf = 1;
      else begin
        exp_re = 1; exp_ra = (mdl_ptr - 3) & M;
        mdl_ptr = (mdl_ptr - 1) & M;
        mdl_cnt--;
      end
    end
    check("ready_pre", 64'(ready_o), 64'(rdy));
    check("mem_wea", 64'(mem_wea), 64'(exp_we));
    if (exp_we) begin
      check("mem_waddra", 64'(mem_waddra), 64'(exp_wa));
      check("mem_wia", 64'(mem_wia), 64'(d));
    end
    check("mem_reb", 64'(mem_reb), 64'(exp_re));
    if (exp_re) check("mem_raddrb", 64'(mem_raddrb), 64'(exp_ra));
    @(posedge clk);
    #1;
    check("ptr", 64'(ptr_o), 64'(mdl_ptr));
    check("count", 64'(count_o), 64'(mdl_cnt));
    check("overflow", 64'(overflow_o), 64'(exp_ovf));
    check("underflow", 64'(underflow_o), 64'(exp_udf));
    check("ready", 64'(ready_o), 64'(mdl_busy == 0));
    check("top_valid", 64'(top_valid_o), 64'(mdl_cnt != 0));
    if (mdl_busy == 0 && mdl_cnt > 0)
      check("top", 64'(top_o), 64'(mdl_mem[(mdl_ptr - 1) & M]));
    $display("cyc push=%0b pop=%0b d=%02h rec=%0b -> ptr=%0d cnt=%0d top=%02h rdy=%0b ovf=%0b udf=%0b",
             p, q, d, r, ptr_o, count_o, top_o, ready_o, overflow_o, underflow_o);
  endtask

  task automatic push(input logic [WIDTH-1:0] d); cycle(1, 0, d, 0, 0, 0); endtask
  task automatic pop();                           cycle(0, 1, '0, 0, 0, 0); endtask
  task automatic idle();                          cycle(0, 0, '0, 0, 0, 0); endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      bram[i] = '0;
      mdl_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready_o), 64'(1));
    check("rst_top", 64'(top_o), 64'(0));
    check("rst_top_valid", 64'(top_valid_o), 64'(0));
    check("rst_count", 64'(count_o), 64'(0));
    check("rst_ptr", 64'(ptr_o), 64'(0));
    check("rst_ovf", 64'(overflow_o), 64'(0));
    check("rst_udf", 64'(underflow_o), 64'(0));
    check("rst_wea", 64'(mem_wea), 64'(0));
    check("rst_reb", 64'(mem_reb), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic push then back-to-back pops down to empty and one past it.
    push(8'h11); push(8'h22); push(8'h33);
    check("d1_top", 64'(top_o), 64'(8'h33));
    check("d1_count", 64'(count_o), 64'(3));
    check("d1_ptr", 64'(ptr_o), 64'(3));
    pop(); check("d2_top0", 64'(top_o), 64'(8'h22));
    pop(); check("d2_top1", 64'(top_o), 64'(8'h11));
    pop(); check("d2_valid", 64'(top_valid_o), 64'(0));
    pop(); check("d2_udf", 64'(underflow_o), 64'(1));
    check("d2_count", 64'(count_o), 64'(0));

    // Overflow: the oldest entry is lost, the newest DEPTH survive.
    for (int i = 1; i <= 5; i++) push(WIDTH'(8'hA0 + i));
    check("d3_ovf", 64'(overflow_o), 64'(1));
    check("d3_count", 64'(count_o), 64'(4));
    pop(); check("d3_pop0", 64'(top_o), 64'(8'hA4));
    pop(); check("d3_pop1", 64'(top_o), 64'(8'hA3));
    pop(); check("d3_pop2", 64'(top_o), 64'(8'hA2));
    pop(); check("d3_empty", 64'(count_o), 64'(0));

    // Replace top with simultaneous push+pop.
    push(8'h10); push(8'h20);
    cycle(1, 1, 8'h30, 0, 0, 0);
    check("d4_top", 64'(top_o), 64'(8'h30));
    check("d4_count", 64'(count_o), 64'(2));
    pop(); check("d4_pop", 64'(top_o), 64'(8'h10));

    // Recovery refills from memory, including a slot overwritten after the checkpoint.
    cycle(0, 0, '0, 1, 0, 0); idle(); idle();
    push(8'h10); push(8'h20); push(8'h30);
    check("d5_ptr", 64'(ptr_o), 64'(3));
    pop(); pop(); push(8'h99);
    cycle(0, 0, '0, 1, 3, 3);
    check("d5_busy0", 64'(ready_o), 64'(0));
    cycle(1, 1, 8'h55, 0, 0, 0);
    check("d5_busy1", 64'(ready_o), 64'(0));
    idle();
    check("d5_ready", 64'(ready_o), 64'(1));
    check("d5_top", 64'(top_o), 64'(8'h30));
    pop(); check("d5_pop", 64'(top_o), 64'(8'h99));

    // Asynchronous reset while refilling.
    cycle(0, 0, '0, 1, 2, 2);
    check("d6_busy", 64'(ready_o), 64'(0));
    #2;
    push_i = 0; pop_i = 0; recover_i = 0;
    rst_n = 1'b0;
    #1;
    check("d6_ready", 64'(ready_o), 64'(1));
    check("d6_count", 64'(count_o), 64'(0));
    check("d6_top", 64'(top_o), 64'(0));
    mdl_ptr = 0; mdl_cnt = 0; mdl_busy = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic, including requests during recovery that must be ignored.
    for (int n = 0; n < 3000; n++) begin
      bit r;
      r = ($urandom_range(0, 15) == 0);
      cycle(1'($urandom), 1'($urandom), WIDTH'($urandom), r,
            $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Control/initiator side of the return address stack (RAS): owns stack pointer, occupancy and top-of-stack cache.
- Drives the dual-port RAS BRAM: port A write-only for pushes, port B read-only for refills after pops and recovery.
- Sits between branch-prediction frontend (push on call, pop on return, recover on mispredict) and the BRAM instance.
- Gives zero-bubble back-to-back pop/push to the frontend despite 1-cycle BRAM read latency.

Parameters:
DEPTH, 1024, number of stack entries; must be a power of two, >= 4
WIDTH, 36, return-address width in bits
ADDR (localparam), $clog2(DEPTH), pointer width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
push_i  input  1  push push_addr_i (call)
pop_i  input  1  pop top entry (return)
push_addr_i  input  WIDTH  return address to push
recover_i  input  1  restore checkpointed pointer/count (mispredict)
recover_ptr_i  input  ADDR  restored write pointer
recover_cnt_i  input  ADDR+1  restored occupancy, 0..DEPTH
ready_o  output  1  accepts push/pop/recover this cycle
top_o  output  WIDTH  current top-of-stack address
top_valid_o  output  1  count_o != 0
count_o  output  ADDR+1  occupancy, saturates at DEPTH
ptr_o  output  ADDR  write pointer (next push slot), for checkpointing
overflow_o  output  1  1-cycle pulse: push while full (oldest overwritten)
underflow_o  output  1  1-cycle pulse: pop while empty
mem_wea  output  1  BRAM port A write enable
mem_waddra  output  ADDR  BRAM port A write address
mem_wia  output  WIDTH  BRAM port A write data
mem_reb  output  1  BRAM port B read enable
mem_raddrb  output  ADDR  BRAM port B read address
mem_dob  input  WIDTH  BRAM port B read data, valid 1 cycle after mem_reb
(BRAM rea, web, raddra, waddrb, wib tied 0 at integration; doa unused.)

Behaviour:
- Clock clk; reset asynchronous, active-low on rst_n.
- Reset: ptr=0, count=0, top_q=0, next_q=0, pend=0, state READY; top_o=0, top_valid_o=0, ready_o=1, all mem_* and pulse outputs 0.
- Pointer arithmetic modulo DEPTH (natural ADDR-bit wrap). Entry k below top lives at ptr-1-k.
- Cache: top_q = mem[ptr-1]; next_eff = pend ? mem_dob : next_q = mem[ptr-2]. top_o = top_q combinationally.
- States: READY, REFILL_TOP, REFILL_NEXT. ready_o = (state==READY). push/pop/recover while !ready_o are ignored (no state change, no pulses).
- READY, push only: mem_wea=1, waddra=ptr, wia=push_addr_i; top_q<=push_addr_i; next_q<=top_q; pend<=0; ptr<=ptr+1; count<=min(count+1,DEPTH); overflow_o pulses next cycle if count==DEPTH.
- READY, pop only, count>0: top_q<=next_eff; mem_reb=1, raddrb=ptr-3; pend<=1; ptr<=ptr-1; count<=count-1.
- READY, pop only, count==0: no state change; underflow_o pulses next cycle.
- READY, push+pop same cycle: replace top: write push_addr_i at ptr-1; top_q<=push_addr_i; ptr/count unchanged; if pend, next_q<=mem_dob, pend<=0. If count==0 treat as push only.
- READY, idle with pend=1: next_q<=mem_dob, pend<=0.
- recover_i (priority over push/pop): ptr<=recover_ptr_i, count<=recover_cnt_i, pend<=0; issue read recover_ptr_i-1; go REFILL_TOP.
- REFILL_TOP: top_q<=mem_dob; issue read ptr-2; go REFILL_NEXT.
- REFILL_NEXT: next_q<=mem_dob; go READY. Recovery is 2 cycles not-ready.
- Entries below count are don't-care; reads of them are harmless, top_valid_o is count-gated.
- After overflow, pops return the most recent DEPTH pushes, then count reaches 0.
- Port A only writes, port B only reads: no same-port collisions; same-cycle write/read addresses differ by construction.
- Reset mid-refill aborts to READY with reset values.

Test Plan:
- DEPTH=4, WIDTH=8: push 0x11,0x22,0x33 -> top_o=0x33, count_o=3, ptr_o=3, writes at 0,1,2.
- Then pop on 3 consecutive cycles -> top_o 0x22, 0x11, then top_valid_o=0, count_o=0, no bubbles; 4th pop -> underflow_o pulse, count stays 0.
- Push 0xA1..0xA5 (5 pushes) -> overflow_o pulse on 5th, count_o=4; pops yield 0xA4,0xA3,0xA2, then count_o=0 after 4 pops.
- Push 0x10,0x20, then push+pop 0x30 -> top_o=0x30, count_o=2; pop -> top_o=0x10.
- Push 0x10,0x20,0x30, save ptr=3/cnt=3, pop twice, push 0x99, recover(3,3) -> ready_o low 2 cycles, then top_o=0x30, next pop -> 0x20 only if slot 1 was not overwritten (0x99 overwrote slot 1, so 0x99); checks memory-backed refill.
- Assert rst_n low during REFILL_TOP -> ready_o=1, count_o=0, top_o=0 immediately (asynchronously).
